// File: rtl/axi_write_slave.sv
// AXI4 write-channel slave: one outstanding FIXED/INCR/WRAP burst onto a zero-latency memory write port.
// Optional macro AXI_WR_SLVERR_EN: SLVERR on illegal burst/size or wlast mismatch.
module axi_write_slave #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    awvalid,
   output logic                    awready,
   input  logic [ID_WIDTH-1:0]     awid,
   input  logic [ADDR_WIDTH-1:0]   awaddr,
   input  logic [7:0]              awlen,
   input  logic [2:0]              awsize,
   input  logic [1:0]              awburst,
   input  logic                    wvalid,
   output logic                    wready,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   input  logic                    wlast,
   output logic                    bvalid,
   input  logic                    bready,
   output logic [ID_WIDTH-1:0]     bid,
   output logic [1:0]              bresp,
   output logic                    mem_write_en,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   output logic [DATA_WIDTH/8-1:0] mem_wstrb
);

   localparam int STRB_W = DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_RESP
   } state_t;

   state_t                state_q;
   logic                  awready_q;
   logic                  wready_q;
   logic                  bvalid_q;
   logic [1:0]            bresp_q;
   logic [ID_WIDTH-1:0]   id_q;
   logic [ADDR_WIDTH-1:0] cur_addr_q;
   logic [7:0]            len_q;
   logic [7:0]            beat_cnt_q;
   logic [2:0]            size_q;
   logic [1:0]            burst_q;

   logic                  beat;
   logic                  last_beat;
   logic                  resp_err;
   logic [ADDR_WIDTH-1:0] incr;
   logic [ADDR_WIDTH-1:0] wrap_mask;
   logic [ADDR_WIDTH-1:0] next_addr_d;

   assign beat      = wvalid & wready_q;
   assign last_beat = (beat_cnt_q == len_q);
   assign incr      = ADDR_WIDTH'(1) << size_q;
   assign wrap_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q)
                      - ADDR_WIDTH'(1);

   // WRAP keeps the upper bits of the aligned window and wraps the offset.
   always_comb begin
      next_addr_d = cur_addr_q + incr;
      case (burst_q)
         2'b00:   next_addr_d = cur_addr_q;
         2'b10:   next_addr_d = (cur_addr_q & ~wrap_mask)
                              | ((cur_addr_q + incr) & wrap_mask);
         default: next_addr_d = cur_addr_q + incr;
      endcase
   end

`ifdef AXI_WR_SLVERR_EN
   localparam int LG_STRB = $clog2(STRB_W);

   logic ill_q;
   logic err_q;
   logic aw_ill;
   logic wl_err;

   assign aw_ill   = (awburst == 2'b11) | (awsize > 3'(LG_STRB));
   assign wl_err   = beat & (wlast != last_beat);
   assign resp_err = err_q | wl_err;
   assign mem_write_en = beat & ~ill_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ill_q <= 1'b0;
         err_q <= 1'b0;
      end else if (state_q == S_IDLE) begin
         if (awvalid & awready_q) begin
            ill_q <= aw_ill;
            err_q <= aw_ill;
         end else begin
            ill_q <= 1'b0;
            err_q <= 1'b0;
         end
      end else if (wl_err) begin
         err_q <= 1'b1;
      end
   end
`else
   logic unused_wlast;

   assign unused_wlast = wlast;
   assign resp_err     = 1'b0;
   assign mem_write_en = beat;
`endif

   assign awready   = awready_q;
   assign wready    = wready_q;
   assign bvalid    = bvalid_q;
   assign bid       = id_q;
   assign bresp     = bresp_q;
   assign mem_addr  = cur_addr_q;
   assign mem_wdata = mem_write_en ? wdata : '0;
   assign mem_wstrb = mem_write_en ? wstrb : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         bresp_q    <= 2'b00;
         id_q       <= '0;
         cur_addr_q <= '0;
         len_q      <= '0;
         beat_cnt_q <= '0;
         size_q     <= '0;
         burst_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               awready_q <= 1'b1;
               if (awvalid & awready_q) begin
                  awready_q  <= 1'b0;
                  wready_q   <= 1'b1;
                  id_q       <= awid;
                  cur_addr_q <= awaddr;
                  len_q      <= awlen;
                  size_q     <= awsize;
                  burst_q    <= awburst;
                  beat_cnt_q <= '0;
                  state_q    <= S_DATA;
               end
            end
            S_DATA: begin
               if (beat) begin
                  cur_addr_q <= next_addr_d;
                  beat_cnt_q <= beat_cnt_q + 8'd1;
                  if (last_beat) begin
                     wready_q <= 1'b0;
                     bvalid_q <= 1'b1;
                     bresp_q  <= resp_err ? 2'b10 : 2'b00;
                     state_q  <= S_RESP;
                  end
               end
            end
            S_RESP: begin
               if (bready) begin
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  state_q   <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_write_slave.sv
// Directed bench for axi_write_slave: reset, INCR/WRAP/FIXED bursts, B backpressure, mid-burst reset.
// Build with AXI_WR_SLVERR_EN defined to exercise the SLVERR checks.
module tb_axi_write_slave;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [3:0]  awid = '0;
   logic [31:0] awaddr = '0;
   logic [7:0]  awlen = '0;
   logic [2:0]  awsize = '0;
   logic [1:0]  awburst = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wlast = 1'b0;
   logic        bvalid;
   logic        bready = 1'b0;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        mem_write_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;

   int checks = 0;
   int passed = 0;

   logic [31:0] log_a[$];
   logic [31:0] log_d[$];
   logic [3:0]  log_s[$];

   axi_write_slave #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32),
      .ID_WIDTH  (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .awvalid     (awvalid),
      .awready     (awready),
      .awid        (awid),
      .awaddr      (awaddr),
      .awlen       (awlen),
      .awsize      (awsize),
      .awburst     (awburst),
      .wvalid      (wvalid),
      .wready      (wready),
      .wdata       (wdata),
      .wstrb       (wstrb),
      .wlast       (wlast),
      .bvalid      (bvalid),
      .bready      (bready),
      .bid         (bid),
      .bresp       (bresp),
      .mem_write_en(mem_write_en),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_wstrb   (mem_wstrb)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mem_write_en === 1'b1) begin
         log_a.push_back(mem_addr);
         log_d.push_back(mem_wdata);
         log_s.push_back(mem_wstrb);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      log_a.delete();
      log_d.delete();
      log_s.delete();
   endtask

   task automatic send_aw(input logic [3:0] id, input logic [31:0] a,
                          input logic [7:0] l, input logic [2:0] s,
                          input logic [1:0] b);
      int n = 0;
      awvalid = 1'b1;
      awid    = id;
      awaddr  = a;
      awlen   = l;
      awsize  = s;
      awburst = b;
      #1;
      while (awready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (awready !== 1'b1) $display("FAIL aw_timeout awready=%b want 1", awready);
      else passed++;
      tick();
      awvalid = 1'b0;
   endtask

   task automatic send_w(input int n, input logic [31:0] base, input int last_at);
      for (int i = 0; i < n; i++) begin
         wvalid = 1'b1;
         wdata  = base + 32'(i);
         wstrb  = 4'hF;
         wlast  = (i == last_at);
         tick();
      end
      wvalid = 1'b0;
      wlast  = 1'b0;
   endtask

   task automatic finish_b();
      int n = 0;
      bready = 1'b1;
      #1;
      while (bvalid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (bvalid !== 1'b1) $display("FAIL b_timeout bvalid=%b want 1", bvalid);
      else passed++;
      tick();
      bready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) tick();
      checks++;
      if ({awready, wready, bvalid, mem_write_en} !== 4'b0000)
         $display("FAIL reset_ctrl got %b want 0000",
                  {awready, wready, bvalid, mem_write_en});
      else passed++;
      checks++;
      if ({mem_addr, bid, bresp} !== 38'd0)
         $display("FAIL reset_regs addr=%h bid=%h bresp=%b want 0",
                  mem_addr, bid, bresp);
      else passed++;
      rst = 1'b0;
      tick();
      checks++;
      if (awready !== 1'b1) $display("FAIL idle_awready got %b want 1", awready);
      else passed++;
   endtask

   task automatic test_single();
      clear_log();
      awvalid = 1'b1;
      awid    = 4'h5;
      awaddr  = 32'h100;
      awlen   = 8'd0;
      awsize  = 3'd2;
      awburst = 2'b01;
      wvalid  = 1'b1;
      wdata   = 32'hDEADBEEF;
      wstrb   = 4'hF;
      wlast   = 1'b1;
      #1;
      checks++;
      if ({wready, mem_write_en} !== 2'b00)
         $display("FAIL w_stall_idle got %b want 00", {wready, mem_write_en});
      else passed++;
      tick();
      awvalid = 1'b0;
      #1;
      checks++;
      if ({awready, mem_write_en} !== 2'b01)
         $display("FAIL single_beat awready,we got %b want 01", {awready, mem_write_en});
      else passed++;
      checks++;
      if (mem_addr !== 32'h100 || mem_wdata !== 32'hDEADBEEF)
         $display("FAIL single_port addr=%h data=%h want 100/deadbeef", mem_addr, mem_wdata);
      else passed++;
      tick();
      wvalid = 1'b0;
      wlast  = 1'b0;
      checks++;
      if ({bvalid, bid, bresp, wready} !== {1'b1, 4'h5, 2'b00, 1'b0})
         $display("FAIL single_b bvalid=%b bid=%h bresp=%b wready=%b want 1/5/00/0",
                  bvalid, bid, bresp, wready);
      else passed++;
      bready = 1'b1;
      tick();
      bready = 1'b0;
      checks++;
      if ({bvalid, awready} !== 2'b01)
         $display("FAIL single_done bvalid,awready got %b want 01", {bvalid, awready});
      else passed++;
      checks++;
      if (log_a.size() != 1 || log_a[0] !== 32'h100 || log_s[0] !== 4'hF)
         $display("FAIL single_log n=%0d want 1 at 100 strb F", log_a.size());
      else passed++;
   endtask

   task automatic test_incr_gaps();
      logic [6:0] pat = 7'b1001101;
      int nb = 0;
      clear_log();
      send_aw(4'h3, 32'h200, 8'd3, 3'd2, 2'b01);
      for (int c = 0; c < 7; c++) begin
         wvalid = pat[c];
         wdata  = 32'hA000_0000 + 32'(nb);
         wstrb  = 4'hF;
         wlast  = (nb == 3);
         tick();
         if (pat[c]) nb++;
         if (nb == 3) begin
            checks++;
            if (bvalid !== 1'b0) $display("FAIL incr_early_b got %b want 0", bvalid);
            else passed++;
         end
      end
      wvalid = 1'b0;
      wlast  = 1'b0;
      checks++;
      if ({bvalid, bid, bresp} !== {1'b1, 4'h3, 2'b00})
         $display("FAIL incr_b bvalid=%b bid=%h bresp=%b want 1/3/00", bvalid, bid, bresp);
      else passed++;
      checks++;
      if (log_a.size() != 4) $display("FAIL incr_count got %0d want 4", log_a.size());
      else passed++;
      for (int i = 0; i < 4 && i < log_a.size(); i++) begin
         checks++;
         if (log_a[i] !== 32'h200 + 32'(4 * i) || log_d[i] !== 32'hA000_0000 + 32'(i))
            $display("FAIL incr_beat%0d addr=%h data=%h want %h/%h", i, log_a[i], log_d[i],
                     32'h200 + 32'(4 * i), 32'hA000_0000 + 32'(i));
         else passed++;
      end
      finish_b();
   endtask

   task automatic test_wrap_fixed();
      logic [31:0] wexp[4] = '{32'h108, 32'h10C, 32'h100, 32'h104};
      clear_log();
      send_aw(4'h1, 32'h108, 8'd3, 3'd2, 2'b10);
      send_w(4, 32'hB000_0000, 3);
      finish_b();
      checks++;
      if (log_a.size() != 4) $display("FAIL wrap_count got %0d want 4", log_a.size());
      else passed++;
      for (int i = 0; i < 4 && i < log_a.size(); i++) begin
         checks++;
         if (log_a[i] !== wexp[i])
            $display("FAIL wrap_beat%0d addr=%h want %h", i, log_a[i], wexp[i]);
         else passed++;
      end
      clear_log();
      send_aw(4'h2, 32'h40, 8'd2, 3'd2, 2'b00);
      send_w(3, 32'hC000_0000, 2);
      finish_b();
      checks++;
      if (log_a.size() != 3) $display("FAIL fixed_count got %0d want 3", log_a.size());
      else passed++;
      for (int i = 0; i < 3 && i < log_a.size(); i++) begin
         checks++;
         if (log_a[i] !== 32'h40 || log_d[i] !== 32'hC000_0000 + 32'(i))
            $display("FAIL fixed_beat%0d addr=%h data=%h want 40", i, log_a[i], log_d[i]);
         else passed++;
      end
   endtask

   task automatic test_b_backpressure();
      send_aw(4'h7, 32'h300, 8'd0, 3'd2, 2'b01);
      send_w(1, 32'h1111_1111, 0);
      awvalid = 1'b1;
      awid    = 4'h2;
      awaddr  = 32'h400;
      awlen   = 8'd0;
      awsize  = 3'd2;
      awburst = 2'b01;
      bready  = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         checks++;
         if ({bvalid, bid, bresp, awready} !== {1'b1, 4'h7, 2'b00, 1'b0})
            $display("FAIL bp_hold%0d bvalid=%b bid=%h bresp=%b awready=%b want 1/7/00/0",
                     k, bvalid, bid, bresp, awready);
         else passed++;
         tick();
      end
      bready = 1'b1;
      tick();
      bready = 1'b0;
      checks++;
      if ({awready, bvalid} !== 2'b10)
         $display("FAIL bp_idle awready,bvalid got %b want 10", {awready, bvalid});
      else passed++;
      tick();
      awvalid = 1'b0;
      checks++;
      if ({wready, awready} !== 2'b10)
         $display("FAIL bp_second_aw wready,awready got %b want 10", {wready, awready});
      else passed++;
      send_w(1, 32'h2222_2222, 0);
      checks++;
      if (bid !== 4'h2) $display("FAIL bp_second_bid got %h want 2", bid);
      else passed++;
      finish_b();
   endtask

   task automatic test_reset_midburst();
      clear_log();
      send_aw(4'h9, 32'h500, 8'd3, 3'd2, 2'b01);
      wvalid = 1'b1;
      wdata  = 32'h5555_0000;
      wstrb  = 4'hF;
      wlast  = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      checks++;
      if ({awready, wready, bvalid, mem_write_en} !== 4'b0000 || mem_addr !== 32'h0
          || bid !== 4'h0)
         $display("FAIL rst_mid ctrl=%b addr=%h bid=%h want 0",
                  {awready, wready, bvalid, mem_write_en}, mem_addr, bid);
      else passed++;
      tick();
      tick();
      wvalid = 1'b0;
      rst = 1'b0;
      checks++;
      if (bvalid !== 1'b0) $display("FAIL rst_mid_nob got %b want 0", bvalid);
      else passed++;
      checks++;
      if (log_a.size() != 1) $display("FAIL rst_mid_writes got %0d want 1", log_a.size());
      else passed++;
      tick();
      clear_log();
      send_aw(4'h4, 32'h600, 8'd1, 3'd2, 2'b01);
      send_w(2, 32'h6666_0000, 1);
      checks++;
      if ({bvalid, bid, bresp} !== {1'b1, 4'h4, 2'b00} || log_a.size() != 2)
         $display("FAIL rst_recover bvalid=%b bid=%h bresp=%b n=%0d want 1/4/00/2",
                  bvalid, bid, bresp, log_a.size());
      else passed++;
      checks++;
      if (log_a.size() == 2 && (log_a[0] !== 32'h600 || log_a[1] !== 32'h604))
         $display("FAIL rst_recover_addr got %h,%h want 600,604", log_a[0], log_a[1]);
      else passed++;
      finish_b();
   endtask

`ifdef AXI_WR_SLVERR_EN
   task automatic test_slverr();
      clear_log();
      send_aw(4'h1, 32'h800, 8'd1, 3'd2, 2'b01);
      send_w(2, 32'h8888_0000, 0);
      checks++;
      if ({bvalid, bresp} !== 3'b110 || log_a.size() != 2)
         $display("FAIL slverr_wlast bvalid=%b bresp=%b n=%0d want 1/10/2",
                  bvalid, bresp, log_a.size());
      else passed++;
      finish_b();
      clear_log();
      send_aw(4'h2, 32'h900, 8'd1, 3'd2, 2'b11);
      send_w(2, 32'h9999_0000, 1);
      checks++;
      if ({bvalid, bresp} !== 3'b110 || log_a.size() != 0)
         $display("FAIL slverr_burst bvalid=%b bresp=%b n=%0d want 1/10/0",
                  bvalid, bresp, log_a.size());
      else passed++;
      finish_b();
      clear_log();
      send_aw(4'h3, 32'hA00, 8'd0, 3'd3, 2'b01);
      send_w(1, 32'hAAAA_0000, 0);
      checks++;
      if ({bvalid, bresp} !== 3'b110 || log_a.size() != 0)
         $display("FAIL slverr_size bvalid=%b bresp=%b n=%0d want 1/10/0",
                  bvalid, bresp, log_a.size());
      else passed++;
      finish_b();
      send_aw(4'h4, 32'hB00, 8'd0, 3'd2, 2'b01);
      send_w(1, 32'hBBBB_0000, 0);
      checks++;
      if (bresp !== 2'b00) $display("FAIL slverr_clear got %b want 00", bresp);
      else passed++;
      finish_b();
   endtask
`else
   task automatic test_no_checking();
      clear_log();
      send_aw(4'h6, 32'h700, 8'd1, 3'd2, 2'b11);
      send_w(2, 32'h7777_0000, -1);
      checks++;
      if ({bvalid, bid, bresp} !== {1'b1, 4'h6, 2'b00})
         $display("FAIL burst11_b bvalid=%b bid=%h bresp=%b want 1/6/00", bvalid, bid, bresp);
      else passed++;
      checks++;
      if (log_a.size() != 2 || log_a[0] !== 32'h700 || log_a[1] !== 32'h704)
         $display("FAIL burst11_incr n=%0d want 2 beats at 700,704", log_a.size());
      else passed++;
      finish_b();
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_incr_gaps();
      test_wrap_fixed();
      test_b_backpressure();
      test_reset_midburst();
`ifdef AXI_WR_SLVERR_EN
      test_slverr();
`else
      test_no_checking();
`endif
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
